universal_shift_register: RTL
=============================

# universal_shift_register

Parametrised, multi-mode successor to the team's 8-bit serial-in shift register. It holds a WIDTH-bit register that can hold, shift or rotate in either direction, shift arithmetically, parallel-load or clear. A burst sequencer runs a programmed number of shift/rotate steps autonomously, with busy/done status. It sits between serial links and parallel datapaths as a SIPO/PISO/barrel-step element.

## Interface
- WIDTH, 8: register width in bits (≥2).
- COUNT_W, 4: width of the burst count; maximum burst is 2^COUNT_W−1 steps.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  performs one manual operation this cycle (ignored while busy).
- mode  in  3  operation select (encoding below).
- data  in  1  serial input bit for shift modes.
- load_val  in  WIDTH  parallel load value.
- start  in  1  launches a burst of `count` steps of `mode`.
- count  in  COUNT_W  burst length; sampled with start.
- out  out  WIDTH  register contents.
- ser_out_left  out  1  = out[WIDTH-1], combinational.
- ser_out_right  out  1  = out[0], combinational.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.

## Operation
Mode encoding:
- 000 HOLD: no change.
- 001 SHL: out ← {out[WIDTH-2:0], data}.
- 010 SHR: out ← {data, out[WIDTH-1:1]}.
- 011 ROL: out ← {out[WIDTH-2:0], out[WIDTH-1]}.
- 100 ROR: out ← {out[0], out[WIDTH-1:1]}.
- 101 LOAD: out ← load_val.
- 110 ASR: out ← {out[WIDTH-1], out[WIDTH-1:1]}.
- 111 CLR: out ← 0.

The block is controlled by a two-state FSM, IDLE and BURST.

IDLE:
- With start=0 and en=1: perform `mode` once.
- With start=1 and `mode` a step mode (SHL, SHR, ROL, ROR, ASR) and count>0:
  - latch the mode and remaining = count;
  - busy ← 1; go to BURST;
  - the register does not change on this edge.
- With start=1 and count=0, or with a non-step mode (HOLD, LOAD, CLR): no register change; done ← 1 for one cycle; stay IDLE.
- start has priority over en when both are asserted.

BURST:
- Each edge performs the latched operation and decrements remaining.
- SHL/SHR sample `data` live on every step.
- en, mode, start, count and load_val are ignored.
- On the edge that performs the final step: busy ← 0, done ← 1, go to IDLE.

Reset:
- reset=1 overrides everything: out=0, busy=0, done=0, state IDLE, remaining=0.
- Reset asserted mid-burst aborts the burst; no done pulse is produced.

## Timing
- All state changes occur on the rising clk edge; a manual operation is visible on `out` after 1 edge.
- Burst with count=N, start sampled at edge t0:
  - busy is high after t0;
  - steps occur at edges t0+1 … t0+N;
  - busy falls and done rises after edge t0+N;
  - done falls after t0+N+1.
  - busy is high for exactly N cycles.
- A new start is accepted in the cycle done is high (the FSM is IDLE), giving back-to-back bursts with no gap cycle.
- A zero-length or non-step start: done is high for the one cycle after t0; busy never rises.
- ser_out_left and ser_out_right follow `out` with no added latency.
- Reset values of all outputs: out=0, ser_out_left=0, ser_out_right=0, busy=0, done=0.

## Test plan
(All scenarios use WIDTH=8.)
- Reset then idle: assert reset 2 cycles with en=1, mode=LOAD, load_val=0xFF → out=0x00, busy=0, done=0 throughout and after release.
- Manual ops:
  - LOAD 0xA5, then SHL with data=1 → 0x4B, then SHR with data=0 → 0x25;
  - LOAD 0x81, then ROR → 0xC0, then ROL → 0x81;
  - LOAD 0x80, then ASR → 0xC0.
  - ser_out_left/right track bits 7/0 at every step.
- Burst SHL: out=0x00, start, mode=SHL, count=3, data held at 1 → busy exactly 3 cycles, out=0x01, 0x03, 0x07, one done pulse. en toggled with mode=CLR during the burst has no effect.
- Zero/invalid burst:
  - start with count=0 → done pulse next cycle, busy stays 0, out unchanged;
  - start with mode=LOAD, count=5 → same result;
  - start and en in the same cycle → manual op suppressed.
- Reset mid-burst: ROL burst of count=10 from 0x01, reset after 4 steps (out=0x10) → out=0, busy=0, no done pulse; a fresh start then behaves normally.
- Back-to-back bursts: start SHR, count=2, then re-assert start during the done cycle with ASR, count=2 on 0x80 load path → second burst begins immediately; total busy is 4 of 5 cycles; two done pulses.

Source files
------------

// File: rtl/universal_shift_register_if.sv
// Bus bundle for universal_shift_register: manual-op/burst controls in,
// register contents and burst status out.
interface universal_shift_register_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4
);
  logic               en;
  logic [2:0]         mode;
  logic               data;
  logic [WIDTH-1:0]   load_val;
  logic               start;
  logic [COUNT_W-1:0] count;
  logic [WIDTH-1:0]   out;
  logic               ser_out_left;
  logic               ser_out_right;
  logic               busy;
  logic               done;

  // Driver side (controller / bench)
  modport master (
    output en, mode, data, load_val, start, count,
    input  out, ser_out_left, ser_out_right, busy, done
  );

  // Shift register side
  modport slave (
    input  en, mode, data, load_val, start, count,
    output out, ser_out_left, ser_out_right, busy, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register: hold/shift/rotate/ASR/load/clear, plus a burst
// sequencer that repeats one step mode a programmed number of times.
module universal_shift_register #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  universal_shift_register_if.slave bus
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_LOAD = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q;
  op_t                mode_q;
  logic [COUNT_W-1:0] rem_q;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               busy_q, done_q;

  op_t  op_sel;
  op_t  mode_in;
  logic start_ok;

  assign mode_in = op_t'(bus.mode);

  // During a burst the latched mode drives the datapath; otherwise the live one.
  assign op_sel = (state_q == BURST) ? mode_q : mode_in;

  // Only shifting/rotating modes with a nonzero count launch a real burst.
  assign start_ok = (bus.count != '0) &&
                    (mode_in inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR});

  // One-step result of the selected operation applied to the current contents.
  always_comb begin
    out_d = out_q;
    unique case (op_sel)
      OP_HOLD: out_d = out_q;
      OP_SHL:  out_d = {out_q[WIDTH-2:0], bus.data};
      OP_SHR:  out_d = {bus.data, out_q[WIDTH-1:1]};
      OP_ROL:  out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      OP_ROR:  out_d = {out_q[0], out_q[WIDTH-1:1]};
      OP_LOAD: out_d = bus.load_val;
      OP_ASR:  out_d = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
      OP_CLR:  out_d = '0;
      default: out_d = out_q;
    endcase
  end

  // Control FSM with registered busy/done and the data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= OP_HOLD;
      rem_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            // start wins over en; the register is untouched on the launch edge
            if (start_ok) begin
              mode_q  <= mode_in;
              rem_q   <= bus.count;
              busy_q  <= 1'b1;
              state_q <= BURST;
            end else begin
              done_q <= 1'b1;
            end
          end else if (bus.en) begin
            out_q <= out_d;
          end
        end
        BURST: begin
          out_q <= out_d;
          rem_q <= rem_q - COUNT_W'(1);
          if (rem_q == COUNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out           = out_q;
  assign bus.ser_out_left  = out_q[WIDTH-1];
  assign bus.ser_out_right = out_q[0];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule
